riscv_writeback_ext: RTL and testbench
======================================

# riscv_writeback_ext

Parametrised writeback stage for the pipelined RV32I core: the M→W pipeline register plus result selection. Adds three things: stall/flush control, an N-way result-source mux driven from the registered W-stage select, and load-data alignment with sign/zero extension. It also adds a retired-instruction counter. It sits between the memory stage and the register file write port, and also supplies the W-stage forwarding value.

## Interface
- XLEN, 32, datapath width.
- N_SRC, 5, number of result sources. Source order: 0 ALU, 1 MEM, 2 PC+4, 3 PCTarget, 4 immediate.
- MEM_SRC, 1, source index that receives load extraction.
- CNT_W, 64, width of the retire counter.
- SEL_W (derived, not overridable), $clog2(N_SRC).

- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_stallW  in  1  hold the W register.
- i_flushW  in  1  load a bubble into the W register.
- i_validM  in  1  M stage holds a real instruction.
- i_ctrl_reg_wr_enM  in  1  instruction writes rd.
- i_ctrl_result_srcM  in  SEL_W  result source select.
- i_funct3M  in  3  load type.
- i_addr_lsbM  in  2  byte offset of the load address (ALU result [1:0]).
- i_result_concatM  in  N_SRC*XLEN  source k occupies [k*XLEN +: XLEN].
- i_regfile_rd_addrM  in  5  destination register.
- o_validW  out  1  W stage holds a real instruction.
- o_ctrl_reg_wr_enW  out  1  register file write strobe.
- o_regfile_rd_addrW  out  5  write address.
- o_regfile_rd_dataW  out  XLEN  write data and forwarding value.
- o_instret  out  CNT_W  retired-instruction count.

## Operation
- W register fields: valid, wr_en, sel, funct3, addr_lsb, the full source concat, and rd.
- Update at each rising edge, in priority order:
  - i_flushW=1: all fields cleared to 0. Flush wins over stall.
  - else i_stallW=1: all fields hold.
  - else: all fields capture their M inputs.
- o_ctrl_reg_wr_enW = valid & wr_en & (rd != 0). A write to x0 never asserts.
- o_regfile_rd_dataW is combinational from the W register only. It never uses an M-stage select.
  - sel < N_SRC and sel != MEM_SRC: source[sel] unchanged.
  - sel == MEM_SRC: load extraction on word w = source[MEM_SRC]:
    - 000 LB: byte w[8*lsb +: 8], sign-extended to XLEN.
    - 100 LBU: same byte, zero-extended.
    - 001 LH: half w[16*lsb[1] +: 16], sign-extended. lsb[0] is ignored (misaligned accesses are trapped upstream).
    - 101 LHU: same half, zero-extended.
    - 010 LW and all other codes: w unchanged.
  - sel >= N_SRC: output is 0.
- o_instret increments by 1 on each edge where the W register captures with i_validM=1 (not flushed, not stalled). It wraps modulo 2^CNT_W with no saturation.

## Timing
- Latency: inputs on edge n become W outputs after edge n, within the same cycle. Data path is 1 cycle.
- All outputs are 0 while i_rstn=0 and immediately after release. This includes o_instret=0 and o_regfile_rd_dataW=0, since sel=0 and source 0 is 0.
- Reset asserted mid-stall or mid-flush clears asynchronously. The first capture occurs on the first edge after release.
- Stall held for k cycles: outputs are stable for k cycles, o_instret does not change, and the write strobe stays asserted. Re-writing the same value is benign.
- Simultaneous flush and stall: bubble, and no count.
- Simultaneous flush and i_validM=1: bubble, and no count.

## Structure
- The shared header riscv_configs.v gains:
  - load funct3 constants LB, LH, LW, LBU, LHU;
  - result-source index constants SRC_ALU through SRC_IMM.
- Sub-module riscv_load_ext: a combinational unit that takes (word, funct3, lsb) and returns XLEN data. It is reusable in a later cache path.
- The source mux reuses riscv_mux with N_MUX_IN=N_SRC.

## Test plan
- Reset: hold i_rstn=0, drive all inputs nonzero → every output is 0. Release → the first valid capture gives o_instret=1.
- Load extract: MEM word 0x80FF_7F01, sel=1.
  - LB lsb=1 → 0x0000_007F.
  - LB lsb=2 → 0xFFFF_FFFF.
  - LBU lsb=3 → 0x0000_0080.
  - LH lsb=2 → 0xFFFF_80FF.
  - LHU lsb=0 → 0x0000_7F01.
- Select from W: sel=2 with PC+4=0x104 on edge n. Change i_ctrl_result_srcM to 0 on cycle n+1 with stall=1 → data stays 0x104.
- x0 suppression: wr_en=1, rd=0, valid=1 → o_ctrl_reg_wr_enW=0, and o_instret still increments.
- Stall/flush priority: stall=1 for 3 cycles → outputs and o_instret are frozen. Then stall=1 and flush=1 together → o_validW=0, o_ctrl_reg_wr_enW=0, no increment.
- Counter wrap: CNT_W=4, 17 valid captures → o_instret=1.

Source files
------------

// File: rtl/riscv_writeback_ext_pkg.sv
// Shared constants for the writeback stage: load funct3 codes and the
// result-source indices used by the W-stage result mux.
package riscv_writeback_ext_pkg;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Result-source indices into the source concat
    localparam int SRC_ALU    = 0;
    localparam int SRC_MEM    = 1;
    localparam int SRC_PC4    = 2;
    localparam int SRC_PCTGT  = 3;
    localparam int SRC_IMM    = 4;

endpackage

// File: rtl/riscv_load_ext.sv
// Load-data alignment: picks the byte/half addressed by the low address
// bits out of a fetched word and sign- or zero-extends it. Purely
// combinational so it can be dropped into a cache read path later.
module riscv_load_ext
    import riscv_writeback_ext_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_lsb,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection; halves use only lsb[1], misalignment is trapped upstream
    always_comb begin
        byte_s = 8'h00;
        case (i_lsb)
            2'd0:    byte_s = i_word[7:0];
            2'd1:    byte_s = i_word[15:8];
            2'd2:    byte_s = i_word[23:16];
            2'd3:    byte_s = i_word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (i_lsb[1]) begin
            half_s = i_word[31:16];
        end else begin
            half_s = i_word[15:0];
        end
    end

    // Extension according to the load type; unknown codes pass the word through
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            LB:      o_data = {{(XLEN-8){byte_s[7]}}, byte_s};
            LBU:     o_data = {{(XLEN-8){1'b0}}, byte_s};
            LH:      o_data = {{(XLEN-16){half_s[15]}}, half_s};
            LHU:     o_data = {{(XLEN-16){1'b0}}, half_s};
            LW:      o_data = i_word;
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/riscv_mux.sv
// Generic N-input mux over a flat concat; out-of-range selects give zero.
module riscv_mux #(
    parameter int N_MUX_IN = 5,
    parameter int WIDTH    = 32,
    parameter int SEL_W    = $clog2(N_MUX_IN)
)(
    input  logic [N_MUX_IN*WIDTH-1:0] i_concat,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_data
);

    // Scan all inputs; an unmatched select leaves the zero default
    always_comb begin
        o_data = '0;
        for (int k = 0; k < N_MUX_IN; k++) begin
            if (32'(i_sel) == k) begin
                o_data = i_concat[k*WIDTH +: WIDTH];
            end else begin
                o_data = o_data;
            end
        end
    end

endmodule

// File: rtl/riscv_writeback_ext.sv
// Writeback stage: M->W pipeline register with stall/flush, result
// selection from the registered select, load extraction on the MEM
// source, and a retired-instruction counter.
module riscv_writeback_ext
    import riscv_writeback_ext_pkg::*;
#(
    parameter int  XLEN    = 32,
    parameter int  N_SRC   = 5,
    parameter int  MEM_SRC = SRC_MEM,
    parameter int  CNT_W   = 64,
    localparam int SEL_W   = $clog2(N_SRC)
)(
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_stallW,
    input  logic                  i_flushW,
    input  logic                  i_validM,
    input  logic                  i_ctrl_reg_wr_enM,
    input  logic [SEL_W-1:0]      i_ctrl_result_srcM,
    input  logic [2:0]            i_funct3M,
    input  logic [1:0]            i_addr_lsbM,
    input  logic [N_SRC*XLEN-1:0] i_result_concatM,
    input  logic [4:0]            i_regfile_rd_addrM,
    output logic                  o_validW,
    output logic                  o_ctrl_reg_wr_enW,
    output logic [4:0]            o_regfile_rd_addrW,
    output logic [XLEN-1:0]       o_regfile_rd_dataW,
    output logic [CNT_W-1:0]      o_instret
);

    logic                  valid_r;
    logic                  wr_en_r;
    logic [SEL_W-1:0]      sel_r;
    logic [2:0]            funct3_r;
    logic [1:0]            lsb_r;
    logic [N_SRC*XLEN-1:0] concat_r;
    logic [4:0]            rd_r;
    logic [CNT_W-1:0]      instret_r;
    logic [XLEN-1:0]       load_data_s;
    logic [N_SRC*XLEN-1:0] mux_in_s;
    logic                  capture_s;

    // W register: flush beats stall, stall holds, otherwise capture M
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_r  <= 1'b0;
            wr_en_r  <= 1'b0;
            sel_r    <= '0;
            funct3_r <= 3'b000;
            lsb_r    <= 2'b00;
            concat_r <= '0;
            rd_r     <= 5'd0;
        end else if (i_flushW) begin
            valid_r  <= 1'b0;
            wr_en_r  <= 1'b0;
            sel_r    <= '0;
            funct3_r <= 3'b000;
            lsb_r    <= 2'b00;
            concat_r <= '0;
            rd_r     <= 5'd0;
        end else if (i_stallW) begin
            valid_r  <= valid_r;
            wr_en_r  <= wr_en_r;
            sel_r    <= sel_r;
            funct3_r <= funct3_r;
            lsb_r    <= lsb_r;
            concat_r <= concat_r;
            rd_r     <= rd_r;
        end else begin
            valid_r  <= i_validM;
            wr_en_r  <= i_ctrl_reg_wr_enM;
            sel_r    <= i_ctrl_result_srcM;
            funct3_r <= i_funct3M;
            lsb_r    <= i_addr_lsbM;
            concat_r <= i_result_concatM;
            rd_r     <= i_regfile_rd_addrM;
        end
    end

    // A retirement is a real instruction actually entering W
    always_comb begin
        capture_s = i_validM & ~i_flushW & ~i_stallW;
    end

    // Retire counter, wraps naturally at 2^CNT_W
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            instret_r <= '0;
        end else if (capture_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    riscv_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .i_word   (concat_r[MEM_SRC*XLEN +: XLEN]),
        .i_funct3 (funct3_r),
        .i_lsb    (lsb_r),
        .o_data   (load_data_s)
    );

    // Substitute the extracted load value into the MEM slot before the mux
    always_comb begin
        mux_in_s = concat_r;
        mux_in_s[MEM_SRC*XLEN +: XLEN] = load_data_s;
    end

    riscv_mux #(
        .N_MUX_IN (N_SRC),
        .WIDTH    (XLEN),
        .SEL_W    (SEL_W)
    ) u_result_mux (
        .i_concat (mux_in_s),
        .i_sel    (sel_r),
        .o_data   (o_regfile_rd_dataW)
    );

    // Outputs derived only from W-stage state; writes to x0 are suppressed
    always_comb begin
        o_validW           = valid_r;
        o_ctrl_reg_wr_enW  = valid_r & wr_en_r & (rd_r != 5'd0);
        o_regfile_rd_addrW = rd_r;
        o_instret          = instret_r;
    end

endmodule

// File: tb/tb_riscv_writeback_ext.sv
// Self-checking bench for riscv_writeback_ext: load-extraction vector table,
// hand-written stall/flush/reset/wrap sequences and a randomized phase,
// all checked against a behavioural model of the W stage.
module tb_riscv_writeback_ext;

    localparam int XLEN  = 32;
    localparam int N_SRC = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  stall, flush, valid_m, wr_m;
    logic [2:0]            sel_m;
    logic [2:0]            f3_m;
    logic [1:0]            lsb_m;
    logic [N_SRC*XLEN-1:0] concat_m;
    logic [4:0]            rd_m;

    logic                  valid_w, wr_w, valid_w4, wr_w4;
    logic [4:0]            rd_w, rd_w4;
    logic [31:0]           data_w, data_w4;
    logic [63:0]           instret;
    logic [3:0]            instret4;

    always #5 clk = ~clk;

    riscv_writeback_ext dut (
        .i_clk(clk), .i_rstn(rst_n), .i_stallW(stall), .i_flushW(flush),
        .i_validM(valid_m), .i_ctrl_reg_wr_enM(wr_m), .i_ctrl_result_srcM(sel_m),
        .i_funct3M(f3_m), .i_addr_lsbM(lsb_m), .i_result_concatM(concat_m),
        .i_regfile_rd_addrM(rd_m), .o_validW(valid_w), .o_ctrl_reg_wr_enW(wr_w),
        .o_regfile_rd_addrW(rd_w), .o_regfile_rd_dataW(data_w), .o_instret(instret)
    );

    riscv_writeback_ext #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rstn(rst_n), .i_stallW(stall), .i_flushW(flush),
        .i_validM(valid_m), .i_ctrl_reg_wr_enM(wr_m), .i_ctrl_result_srcM(sel_m),
        .i_funct3M(f3_m), .i_addr_lsbM(lsb_m), .i_result_concatM(concat_m),
        .i_regfile_rd_addrM(rd_m), .o_validW(valid_w4), .o_ctrl_reg_wr_enW(wr_w4),
        .o_regfile_rd_addrW(rd_w4), .o_regfile_rd_dataW(data_w4), .o_instret(instret4)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: the instruction currently sitting in W, plus a count
    logic                  m_valid, m_wr;
    logic [2:0]            m_sel, m_f3;
    logic [1:0]            m_lsb;
    logic [N_SRC*XLEN-1:0] m_concat;
    logic [4:0]            m_rd;
    logic [63:0]           m_cnt;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_vec_t;
    ld_vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_wr = 1'b0; m_sel = 3'd0; m_f3 = 3'd0; m_lsb = 2'd0;
        m_concat = '0; m_rd = 5'd0; m_cnt = 64'd0;
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] w, b, h;
        if (m_sel >= 3'd5) return 32'd0;
        w = m_concat[32*m_sel +: 32];
        if (m_sel != 3'd1) return w;
        b = (w >> (8 * m_lsb)) & 32'hFF;
        h = (w >> (16 * (m_lsb / 2))) & 32'hFFFF;
        case (m_f3)
            3'b000:  return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_valid = 1'b0; m_wr = 1'b0; m_sel = 3'd0; m_f3 = 3'd0; m_lsb = 2'd0;
            m_concat = '0; m_rd = 5'd0;
        end else if (!stall) begin
            m_valid = valid_m; m_wr = wr_m; m_sel = sel_m; m_f3 = f3_m;
            m_lsb = lsb_m; m_concat = concat_m; m_rd = rd_m;
            if (valid_m) m_cnt = m_cnt + 64'd1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic exp_wr;
        exp_wr = m_valid && m_wr && (m_rd != 5'd0);
        check({tag, ".valid"}, 64'(valid_w), 64'(m_valid));
        check({tag, ".wr_en"}, 64'(wr_w), 64'(exp_wr));
        check({tag, ".rd"}, 64'(rd_w), 64'(m_rd));
        check({tag, ".data"}, 64'(data_w), 64'(model_data()));
        check({tag, ".instret"}, instret, m_cnt);
        check({tag, ".instret4"}, 64'(instret4), 64'(m_cnt[3:0]));
        check({tag, ".data4"}, 64'(data_w4), 64'(model_data()));
        check({tag, ".wr_en4"}, 64'({valid_w4, wr_w4, rd_w4}), 64'({m_valid, exp_wr, m_rd}));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic set_m(input logic v, input logic w, input logic [2:0] s,
                         input logic [2:0] f, input logic [1:0] l, input logic [4:0] r);
        valid_m = v; wr_m = w; sel_m = s; f3_m = f; lsb_m = l; rd_m = r;
    endtask

    task automatic rand_concat();
        for (int k = 0; k < N_SRC; k++) concat_m[32*k +: 32] = $urandom;
    endtask

    initial begin
        logic [63:0] saved_cnt;

        vecs[0] = '{3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F};
        vecs[1] = '{3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vecs[2] = '{3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
        vecs[3] = '{3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF};
        vecs[4] = '{3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[5] = '{3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[6] = '{3'b101, 2'd3, 32'h80FF_7F01, 32'h0000_80FF};
        vecs[7] = '{3'b001, 2'd1, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[8] = '{3'b010, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[9] = '{3'b111, 2'd1, 32'h1234_5678, 32'h1234_5678};

        // Reset with every input driven nonzero
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_m(1'b1, 1'b1, 3'd2, 3'd1, 2'd3, 5'd7);
        rand_concat();
        model_reset();
        repeat (3) step("reset");
        check("reset.data_zero", 64'(data_w), 64'd0);
        rst_n = 1'b1;
        set_m(1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 5'd3);
        step("first_capture");
        check("first_capture.instret", instret, 64'd1);

        // Load extraction table
        for (int i = 0; i < 10; i++) begin
            rand_concat();
            concat_m[32 +: 32] = vecs[i].word;
            set_m(1'b1, 1'b1, 3'd1, vecs[i].f3, vecs[i].lsb, 5'd9);
            step("load_vec");
            check($sformatf("load_vec%0d", i), 64'(data_w), 64'(vecs[i].exp));
        end

        // Result select comes from W, not from M
        concat_m = '0;
        concat_m[64 +: 32] = 32'h0000_0104;
        set_m(1'b1, 1'b1, 3'd2, 3'd0, 2'd0, 5'd4);
        step("sel_pc4");
        check("sel_pc4.data", 64'(data_w), 64'h104);
        sel_m = 3'd0; stall = 1'b1;
        step("sel_stalled");
        check("sel_stalled.data", 64'(data_w), 64'h104);
        stall = 1'b0;

        // Write to x0: strobe suppressed, still counts
        saved_cnt = m_cnt;
        set_m(1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 5'd0);
        step("x0");
        check("x0.wr_en", 64'(wr_w), 64'd0);
        check("x0.instret", instret, saved_cnt + 64'd1);

        // Stall 3 cycles while M changes underneath
        concat_m[0 +: 32] = 32'hDEAD_BEEF;
        set_m(1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 5'd5);
        step("pre_stall");
        saved_cnt = m_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_concat();
            set_m(1'b1, 1'b0, 3'($urandom_range(0, 7)), 3'd0, 2'd0, 5'($urandom));
            step("stall");
            check("stall.data", 64'(data_w), 64'hDEAD_BEEF);
            check("stall.wr_en", 64'(wr_w), 64'd1);
            check("stall.instret", instret, saved_cnt);
        end
        flush = 1'b1;
        step("stall_flush");
        check("stall_flush.valid", 64'(valid_w), 64'd0);
        check("stall_flush.wr_en", 64'(wr_w), 64'd0);
        check("stall_flush.instret", instret, saved_cnt);
        stall = 1'b0;
        step("flush_valid");
        check("flush_valid.instret", instret, saved_cnt);
        flush = 1'b0;

        // Asynchronous reset in the middle of a stall
        set_m(1'b1, 1'b1, 3'd0, 3'd0, 2'd0, 5'd6);
        step("pre_async");
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all("async_reset");
        step("async_hold");
        rst_n = 1'b1; stall = 1'b0;

        // 17 valid captures: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            set_m(1'b1, 1'($urandom), 3'($urandom_range(0, 7)), 3'($urandom), 2'($urandom), 5'($urandom));
            step("wrap");
        end
        check("wrap.instret4", 64'(instret4), 64'd1);
        check("wrap.instret", instret, 64'd17);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_concat();
            set_m(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 3'($urandom),
                  2'($urandom), 5'($urandom));
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
